// File: rtl/uart_rx_if.sv
// Receive-side word port: received word, per-word error flags and the valid/ready handshake.
// The master drives the word; the slave (FIFO or host) drives rx_ready.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampled UART receiver: synchronises rx, qualifies the start bit, samples
// data/parity/stop at bit centres and presents each word with error flags.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line idle, waiting for a high-to-low edge on a tick
// S_START  | confirming the start bit at its centre (glitch filter)
// S_DATA   | sampling DATA_BITS data bits, LSB first
// S_PAR    | sampling the parity bit (only when PARITY != 0)
// S_STOP   | sampling the stop bit, then delivering the word
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      sample_tick,
  input  logic      rx,
  output logic      busy,
  uart_rx_if.master rxo
);

  localparam int             TW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic                 tick_last;
  logic [TW-1:0]        tick_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q;

  logic centre;
  logic handshake;
  logic par_calc;

  assign centre    = sample_tick && (tick_cnt == FULL_M1);
  assign handshake = rxo.rx_valid && rxo.rx_ready;
  assign par_calc  = (^shreg) ^ rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m            <= 1'b1;
      rx_s            <= 1'b1;
      tick_last       <= 1'b1;
      state           <= S_IDLE;
      tick_cnt        <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      par_err_q       <= 1'b0;
      busy            <= 1'b0;
      rxo.rx_data     <= '0;
      rxo.rx_valid    <= 1'b0;
      rxo.parity_err  <= 1'b0;
      rxo.frame_err   <= 1'b0;
      rxo.overrun_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      if (sample_tick) tick_last <= rx_s;

      // Handshake clears first so a delivery or overrun in the same cycle wins.
      if (handshake) begin
        rxo.rx_valid    <= 1'b0;
        rxo.overrun_err <= 1'b0;
      end

      if (sample_tick) begin
        case (state)
          S_IDLE: begin
            if (!rx_s && tick_last) begin
              state     <= S_START;
              busy      <= 1'b1;
              tick_cnt  <= '0;
              bit_cnt   <= '0;
              par_err_q <= 1'b0;
            end
          end
          S_START: begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (!rx_s) begin
                state <= S_DATA;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_PAR: begin
            if (centre) begin
              tick_cnt  <= '0;
              bit_cnt   <= '0;
              state     <= S_STOP;
              par_err_q <= (PARITY == 1) ? par_calc :
                           (PARITY == 2) ? !par_calc : 1'b0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (centre) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= S_IDLE;
              busy     <= 1'b0;
              if (!rxo.rx_valid || rxo.rx_ready) begin
                rxo.rx_data    <= shreg;
                rxo.parity_err <= par_err_q;
                rxo.frame_err  <= !rx_s;
                rxo.rx_valid   <= 1'b1;
              end else begin
                rxo.overrun_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule
